// File: rtl/rv32i_types.sv
// Shared RV32I decode types: control word, mux selects, and the decode-queue entry.
package rv32i_types;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_SR   = 3'd5;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq = 3'd0, bne = 3'd1, blt = 3'd4, bge = 3'd5, bltu = 3'd6, bgeu = 3'd7
  } branch_funct3_t;

  // Ordered so that OP/OP-IMM funct3 casts directly to the base operation.
  typedef enum logic [2:0] {
    alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
  } alu_ops;

  typedef enum logic [2:0] {
    mul, mulh, mulhsu, mulhu, div, divu, rem, remu
  } muldiv_funct3_t;

  typedef enum logic {rs1_out, pc_out} alumux1_sel_t;
  typedef enum logic [2:0] {i_imm, u_imm, b_imm, s_imm, j_imm, rs2_out} alumux2_sel_t;
  typedef enum logic {cmp_rs2, cmp_i_imm} cmpmux_sel_t;
  typedef enum logic [3:0] {
    alu_out, br_en, rf_u_imm, rf_lw, rf_pc_plus4, rf_lb, rf_lbu, rf_lh, rf_lhu
  } regfilemux_sel_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    alu_ops          aluop;
    alumux1_sel_t    alu_sel1;
    alumux2_sel_t    alu_sel2;
    cmpmux_sel_t     cmp_sel;
    branch_funct3_t  cmpop;
    regfilemux_sel_t regfilemux;
    logic            regfile_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            muldiv;
    muldiv_funct3_t  muldiv_op;
  } rv32i_ctrl_word;

  typedef struct packed {
    rv32i_ctrl_word   ctrl;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             rs1_used;
    logic             rs2_used;
    logic             illegal;
  } id_entry_t;

endpackage

// File: rtl/id_insn_decode.sv
// Combinational RV32I decode into a queue entry with illegal detection.
// Build option RV32M_EN: decode OP funct7=0000001 as multiply/divide instead of illegal.
module id_insn_decode
  import rv32i_types::*;
(
  input  logic [31:0] insn,
  input  logic [31:0] pc,
  output id_entry_t   entry
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  id_entry_t  base;
  id_entry_t  dec;
  logic       bad;

  assign opcode = insn[6:0];
  assign funct3 = insn[14:12];
  assign funct7 = insn[31:25];

  // Pass-through fields only; also the whole entry for an illegal instruction.
  always_comb begin
    base             = '0;
    base.ctrl.opcode = opcode;
    base.ctrl.insn   = insn;
    base.ctrl.pc     = pc;
    base.ctrl.funct3 = funct3;
    base.ctrl.funct7 = funct7;
    base.rs1         = insn[19:15];
    base.rs2         = insn[24:20];
    base.rd          = insn[11:7];
  end

  always_comb begin
    dec = base;
    bad = 1'b0;
    case (opcode)
      op_lui: begin
        dec.ctrl.regfile_write = 1'b1;
        dec.ctrl.regfilemux    = rf_u_imm;
      end
      op_auipc: begin
        dec.ctrl.alu_sel1      = pc_out;
        dec.ctrl.alu_sel2      = u_imm;
        dec.ctrl.regfile_write = 1'b1;
      end
      op_jal: begin
        dec.ctrl.alu_sel1      = pc_out;
        dec.ctrl.alu_sel2      = j_imm;
        dec.ctrl.regfile_write = 1'b1;
        dec.ctrl.regfilemux    = rf_pc_plus4;
        dec.ctrl.jump          = 1'b1;
      end
      op_jalr: begin
        dec.rs1_used           = 1'b1;
        dec.ctrl.regfile_write = 1'b1;
        dec.ctrl.regfilemux    = rf_pc_plus4;
        dec.ctrl.jump          = 1'b1;
      end
      op_br: begin
        dec.rs1_used      = 1'b1;
        dec.rs2_used      = 1'b1;
        dec.ctrl.alu_sel1 = pc_out;
        dec.ctrl.alu_sel2 = b_imm;
        dec.ctrl.cmpop    = branch_funct3_t'(funct3);
        dec.ctrl.branch   = 1'b1;
        bad               = (funct3[2:1] == 2'b01);
      end
      op_load: begin
        dec.rs1_used           = 1'b1;
        dec.ctrl.mem_read      = 1'b1;
        dec.ctrl.regfile_write = 1'b1;
        case (funct3)
          3'd0:    dec.ctrl.regfilemux = rf_lb;
          3'd1:    dec.ctrl.regfilemux = rf_lh;
          3'd2:    dec.ctrl.regfilemux = rf_lw;
          3'd4:    dec.ctrl.regfilemux = rf_lbu;
          3'd5:    dec.ctrl.regfilemux = rf_lhu;
          default: bad = 1'b1;
        endcase
      end
      op_store: begin
        dec.rs1_used       = 1'b1;
        dec.rs2_used       = 1'b1;
        dec.ctrl.alu_sel2  = s_imm;
        dec.ctrl.mem_write = 1'b1;
        bad                = (funct3 > 3'd2);
      end
      op_imm: begin
        dec.rs1_used           = 1'b1;
        dec.ctrl.regfile_write = 1'b1;
        dec.ctrl.aluop         = alu_ops'(funct3);
        case (funct3)
          F3_SLT:  begin dec.ctrl.cmpop = blt;  dec.ctrl.cmp_sel = cmp_i_imm; dec.ctrl.regfilemux = br_en; end
          F3_SLTU: begin dec.ctrl.cmpop = bltu; dec.ctrl.cmp_sel = cmp_i_imm; dec.ctrl.regfilemux = br_en; end
          F3_SLL:  bad = (funct7 != F7_BASE);
          F3_SR: begin
            dec.ctrl.aluop = funct7[5] ? alu_sra : alu_srl;
            bad            = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
          default: ;
        endcase
      end
      op_reg: begin
        dec.rs1_used           = 1'b1;
        dec.rs2_used           = 1'b1;
        dec.ctrl.alu_sel2      = rs2_out;
        dec.ctrl.regfile_write = 1'b1;
        dec.ctrl.aluop         = alu_ops'(funct3);
        if (funct7 == F7_BASE) begin
          if (funct3 == F3_SLT) begin
            dec.ctrl.cmpop = blt; dec.ctrl.regfilemux = br_en;
          end else if (funct3 == F3_SLTU) begin
            dec.ctrl.cmpop = bltu; dec.ctrl.regfilemux = br_en;
          end
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD)     dec.ctrl.aluop = alu_sub;
          else if (funct3 == F3_SR) dec.ctrl.aluop = alu_sra;
          else                      bad = 1'b1;
`ifdef RV32M_EN
        end else if (funct7 == F7_MULDIV) begin
          dec.ctrl.muldiv    = 1'b1;
          dec.ctrl.muldiv_op = muldiv_funct3_t'(funct3);
`endif
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    entry = dec;
    if (bad) begin
      entry         = base;
      entry.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_decode_queue.sv
// Decode stage: decodes fetched instructions into a DEPTH-entry circular queue feeding EX,
// with flush and load-use gating of the head. RV32M_EN enables multiply/divide decode.
module id_decode_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  input  logic             ex_load_valid,
  input  logic [4:0]       ex_load_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output rv32i_ctrl_word   out_ctrl,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_rs1_used,
  output logic             out_rs2_used,
  output logic             out_illegal,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  id_entry_t        mem [DEPTH];
  id_entry_t        dec;
  id_entry_t        head;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             empty;
  logic             enq;
  logic             deq;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  id_insn_decode u_decode (
    .insn  (in_insn),
    .pc    (in_pc),
    .entry (dec)
  );

  assign empty    = (count == '0);
  assign in_ready = (count != CNT_W'(DEPTH));
  assign head     = empty ? '0 : mem[rptr];

  assign out_ctrl     = head.ctrl;
  assign out_rs1      = head.rs1;
  assign out_rs2      = head.rs2;
  assign out_rd       = head.rd;
  assign out_rs1_used = head.rs1_used;
  assign out_rs2_used = head.rs2_used;
  assign out_illegal  = head.illegal;

  // Head waits while EX holds a load whose destination it reads.
  assign hazard_stall = !empty && ex_load_valid && (ex_load_rd != 5'd0) &&
                        ((head.rs1_used && (head.rs1 == ex_load_rd)) ||
                         (head.rs2_used && (head.rs2 == ex_load_rd)));
  assign out_valid    = !empty && !hazard_stall;

  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (enq) wptr <= ptr_next(wptr);
      if (deq) rptr <= ptr_next(rptr);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !flush && !rst) mem[wptr] <= dec;
  end

endmodule

// File: tb/tb_id_decode_queue.sv
// Self-checking bench for id_decode_queue: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_id_decode_queue;
  import rv32i_types::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, flush, ex_load_valid, out_valid, out_ready;
  logic [31:0]      in_insn, in_pc;
  logic [4:0]       ex_load_rd, out_rs1, out_rs2, out_rd;
  logic             out_rs1_used, out_rs2_used, out_illegal, hazard_stall;
  logic [CNT_W-1:0] count;
  rv32i_ctrl_word   out_ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { bit ill, rw, mr, mw, u1, u2, md; } ref_t;

  id_decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn),
    .in_pc(in_pc), .flush(flush), .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_rs1_used(out_rs1_used),
    .out_rs2_used(out_rs2_used), .out_illegal(out_illegal), .hazard_stall(hazard_stall),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-class rules straight from the ISA table.
  function automatic ref_t ref_dec(input logic [31:0] w);
    ref_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    r  = '0;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'h37, 7'h17, 7'h6F: r.rw = 1'b1;
      7'h67: begin r.rw = 1'b1; r.u1 = 1'b1; end
      7'h63: begin r.u1 = 1'b1; r.u2 = 1'b1; r.ill = (f3 == 3'd2) || (f3 == 3'd3); end
      7'h03: begin r.rw = 1'b1; r.mr = 1'b1; r.u1 = 1'b1; r.ill = (f3 == 3'd3) || (f3 >= 3'd6); end
      7'h23: begin r.mw = 1'b1; r.u1 = 1'b1; r.u2 = 1'b1; r.ill = (f3 >= 3'd3); end
      7'h13: begin
        r.rw = 1'b1; r.u1 = 1'b1;
        r.ill = ((f3 == 3'd1) && (f7 != 7'h00)) || ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      7'h33: begin
        r.rw = 1'b1; r.u1 = 1'b1; r.u2 = 1'b1;
        if (f7 == 7'h20) r.ill = !((f3 == 3'd0) || (f3 == 3'd5));
        else if (f7 == 7'h01) begin
`ifdef RV32M_EN
          r.md = 1'b1;
`else
          r.ill = 1'b1;
`endif
        end else if (f7 != 7'h00) r.ill = 1'b1;
      end
      default: r.ill = 1'b1;
    endcase
    if (r.ill) begin
      r     = '0;
      r.ill = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w        = $urandom;
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h13;
      8: w[6:0] = 7'h33;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_insn = '0; in_pc = '0; flush = 1'b0;
    ex_load_valid = 1'b0; ex_load_rd = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    n_checks++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %0b expected 0", hazard_stall); end
    n_checks++; if (out_ctrl !== '0 || out_rd !== '0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_head_zero: ctrl nonzero or rd=%0d illegal=%0b", out_rd, out_illegal); end
    tick();
    in_valid = 1'b1; in_insn = 32'h00100113;
    tick(); tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (count !== CNT_W'(2)) begin n_fail++; $display("FAIL prereset_fill: got count %0d expected 2", count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset: count=%0d out_valid=%0b in_ready=%0b expected 0/0/1", count, out_valid, in_ready); end
    tick();
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_insn = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_no_bypass: got out_valid %0b expected 0", out_valid); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_rd !== 5'd1) begin n_fail++; $display("FAIL addi_head: out_valid=%0b rd=%0d expected 1/1", out_valid, out_rd); end
    n_checks++; if (out_ctrl.regfile_write !== 1'b1 || out_ctrl.alu_sel2 !== i_imm || out_illegal !== 1'b0) begin n_fail++; $display("FAIL addi_ctrl: rw=%0b sel2=%0d ill=%0b expected 1/%0d/0", out_ctrl.regfile_write, out_ctrl.alu_sel2, out_illegal, i_imm); end
    n_checks++; if (out_ctrl.pc !== 32'h100 || out_ctrl.insn !== 32'h00500093) begin n_fail++; $display("FAIL addi_passthru: pc=%h insn=%h", out_ctrl.pc, out_ctrl.insn); end
    tick();
    @(negedge clk);
    n_checks++; if (count !== '0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: count=%0d out_valid=%0b expected 0/0", count, out_valid); end
    tick();
  endtask

  task automatic test_fill_order();
    logic [31:0] w [4];
    w[0] = 32'h00100113; w[1] = 32'h00200193; w[2] = 32'h00300213; w[3] = 32'h00400293;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_insn = w[i];
      @(negedge clk);
      n_checks++; if (in_ready !== (i < 2)) begin n_fail++; $display("FAIL fill_in_ready%0d: got %0b expected %0b", i, in_ready, (i < 2)); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (count !== CNT_W'(2 - i) || out_ctrl.insn !== w[i]) begin n_fail++; $display("FAIL drain_order%0d: count=%0d insn=%h expected %0d/%h", i, count, out_ctrl.insn, 2 - i, w[i]); end
      tick();
    end
    in_valid = 1'b1; in_insn = w[3];
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_ctrl.insn !== w[3] || count !== CNT_W'(1)) begin n_fail++; $display("FAIL wrap_entry: valid=%0b insn=%h count=%0d", out_valid, out_ctrl.insn, count); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_hazard();
    out_ready = 1'b0; ex_load_valid = 1'b0; in_valid = 1'b1;
    in_insn = 32'h0000A283; tick();
    in_insn = 32'h00728333; tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_rd !== 5'd5 || out_ctrl.mem_read !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL lw_head: rd=%0d mem_read=%0b valid=%0b", out_rd, out_ctrl.mem_read, out_valid); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; ex_load_valid = 1'b1; ex_load_rd = 5'd5;
    @(negedge clk);
    n_checks++; if (hazard_stall !== 1'b1 || out_valid !== 1'b0 || out_ctrl.insn !== 32'h00728333) begin n_fail++; $display("FAIL hazard_rs1: stall=%0b valid=%0b insn=%h", hazard_stall, out_valid, out_ctrl.insn); end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if (count !== CNT_W'(1) || hazard_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_hold: count=%0d stall=%0b expected 1/1", count, hazard_stall); end
    out_ready = 1'b0; ex_load_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1 || hazard_stall !== 1'b0) begin n_fail++; $display("FAIL hazard_release: valid=%0b stall=%0b", out_valid, hazard_stall); end
    ex_load_valid = 1'b1; ex_load_rd = 5'd0;
    #1;
    n_checks++; if (hazard_stall !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL hazard_x0: stall=%0b valid=%0b", hazard_stall, out_valid); end
    ex_load_rd = 5'd7;
    #1;
    n_checks++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL hazard_rs2: stall=%0b expected 1", hazard_stall); end
    ex_load_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_insn = 32'h00100113; tick(); tick();
    in_insn = 32'h00900493; flush = 1'b1;
    @(negedge clk);
    n_checks++; if (count !== CNT_W'(2)) begin n_fail++; $display("FAIL flush_pre: count=%0d expected 2", count); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full: count=%0d valid=%0b in_ready=%0b", count, out_valid, in_ready); end
    tick();
    in_valid = 1'b1; tick();
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (count !== '0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_enq_deq: count=%0d valid=%0b expected 0/0", count, out_valid); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    out_ready = 1'b0; in_valid = 1'b1;
    in_insn = 32'hFFFFFFFF; tick();
    in_insn = 32'h0020B023; tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_illegal !== 1'b1 || out_ctrl.mem_write !== 1'b0 || out_ctrl.regfile_write !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_ones: ill=%0b mw=%0b rw=%0b valid=%0b", out_illegal, out_ctrl.mem_write, out_ctrl.regfile_write, out_valid); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (out_illegal !== 1'b1 || out_ctrl.mem_write !== 1'b0 || out_ctrl.regfile_write !== 1'b0 || out_ctrl.insn !== 32'h0020B023) begin n_fail++; $display("FAIL illegal_store: ill=%0b mw=%0b rw=%0b insn=%h", out_illegal, out_ctrl.mem_write, out_ctrl.regfile_write, out_ctrl.insn); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_muldiv();
    in_valid = 1'b1; in_insn = 32'h022081B3; tick();
    in_valid = 1'b0;
    @(negedge clk);
`ifdef RV32M_EN
    n_checks++; if (out_ctrl.muldiv !== 1'b1 || out_ctrl.muldiv_op !== mul || out_illegal !== 1'b0 || out_ctrl.regfile_write !== 1'b1) begin n_fail++; $display("FAIL mul_decode: md=%0b op=%0d ill=%0b rw=%0b", out_ctrl.muldiv, out_ctrl.muldiv_op, out_illegal, out_ctrl.regfile_write); end
`else
    n_checks++; if (out_illegal !== 1'b1 || out_ctrl.muldiv !== 1'b0 || out_ctrl.regfile_write !== 1'b0) begin n_fail++; $display("FAIL mul_illegal: ill=%0b md=%0b rw=%0b", out_illegal, out_ctrl.muldiv, out_ctrl.regfile_write); end
`endif
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] qp [$];
    ref_t        h;
    logic        haz, acc_in, acc_out;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      rst           = ($urandom_range(0, 199) == 0);
      in_valid      = ($urandom_range(0, 99) < 60);
      in_insn       = rand_insn();
      in_pc         = $urandom;
      out_ready     = ($urandom_range(0, 99) < 55);
      flush         = ($urandom_range(0, 99) < 3);
      ex_load_valid = 1'($urandom_range(0, 1));
      ex_load_rd    = 5'($urandom_range(0, 7));
      @(negedge clk);
      haz = 1'b0;
      h   = '0;
      if (q.size() != 0) begin
        h   = ref_dec(q[0]);
        haz = ex_load_valid && (ex_load_rd != 5'd0) &&
              ((h.u1 && (q[0][19:15] == ex_load_rd)) || (h.u2 && (q[0][24:20] == ex_load_rd)));
      end
      n_checks++; if (count !== CNT_W'(q.size()) || in_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_occupancy cyc%0d: count=%0d in_ready=%0b expected %0d", cyc, count, in_ready, q.size()); end
      n_checks++; if (hazard_stall !== haz || out_valid !== ((q.size() != 0) && !haz)) begin n_fail++; $display("FAIL rnd_valid cyc%0d: stall=%0b valid=%0b expected stall %0b", cyc, hazard_stall, out_valid, haz); end
      if (q.size() != 0) begin
        n_checks++; if (out_ctrl.insn !== q[0] || out_ctrl.pc !== qp[0]) begin n_fail++; $display("FAIL rnd_order cyc%0d: insn=%h pc=%h expected %h/%h", cyc, out_ctrl.insn, out_ctrl.pc, q[0], qp[0]); end
        n_checks++; if ({out_illegal, out_ctrl.regfile_write, out_ctrl.mem_read, out_ctrl.mem_write, out_rs1_used, out_rs2_used, out_ctrl.muldiv} !== h) begin n_fail++; $display("FAIL rnd_decode cyc%0d insn %h: got %b expected %b", cyc, q[0], {out_illegal, out_ctrl.regfile_write, out_ctrl.mem_read, out_ctrl.mem_write, out_rs1_used, out_rs2_used, out_ctrl.muldiv}, h); end
        n_checks++; if ((h.u1 && out_rs1 !== q[0][19:15]) || (h.u2 && out_rs2 !== q[0][24:20]) || (h.rw && out_rd !== q[0][11:7])) begin n_fail++; $display("FAIL rnd_regs cyc%0d: rs1=%0d rs2=%0d rd=%0d insn %h", cyc, out_rs1, out_rs2, out_rd, q[0]); end
      end else begin
        n_checks++; if (out_ctrl !== '0 || out_rd !== '0 || out_rs1_used !== 1'b0 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL rnd_empty_zero cyc%0d: rd=%0d rs1_used=%0b ill=%0b", cyc, out_rd, out_rs1_used, out_illegal); end
      end
      acc_in  = in_valid && (q.size() < DEPTH);
      acc_out = (q.size() != 0) && !haz && out_ready;
      if (rst || flush) begin
        q.delete(); qp.delete();
      end else begin
        if (acc_out) begin void'(q.pop_front()); void'(qp.pop_front()); end
        if (acc_in) begin q.push_back(in_insn); qp.push_back(in_pc); end
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ex_load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fill_order();
    test_hazard();
    test_flush();
    test_illegal();
    test_muldiv();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
